// File: rtl/prefix_sum_stage_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : prefix_pkg
//  Purpose  : Shared definitions for the multiplier's parallel-prefix adder:
//             tree technique encoding and helpers that derive the number of
//             tree levels and the resulting pipeline latency.
//  Contents : technique_e, tree_levels(), tree_latency()
//  Revision : 1.0  initial release
// ============================================================================
package prefix_pkg;

    typedef enum logic [1:0] {
        KOGGE_STONE = 2'd0,
        SKLANSKY    = 2'd1,
        BRENT_KUNG  = 2'd2
    } technique_e;

    localparam int c_DEFAULT_WIDTH = 64;

    // Brent-Kung needs an up-sweep and a down-sweep, hence the extra levels.
    function automatic int tree_levels(input int width, input technique_e technique);
        int lg;
        lg = $clog2(width);
        case (technique)
            BRENT_KUNG: return 2 * lg - 1;
            default:    return lg;
        endcase
    endfunction

    // A combinational tree has zero latency; a pipelined tree registers
    // every level.
    function automatic int tree_latency(input int width, input technique_e technique,
                                        input bit pipe);
        return pipe ? tree_levels(width, technique) : 0;
    endfunction

endpackage : prefix_pkg
`default_nettype wire

// File: rtl/prefix_sum_stage_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : sum_fifo
//  Purpose  : Synchronous FIFO with a registered head. The head register is
//             loaded from storage, or directly from the push port when the
//             FIFO is otherwise empty, so a pushed entry is visible on the
//             head one cycle after the push. The head data holds its last
//             value while the FIFO is empty.
//  Ports    : clk, rst (sync, active-low)
//             i_push, i_push_data              write side
//             o_head_valid, i_head_ready,
//             o_head_data                      read side (pop = valid&&ready)
//  Revision : 1.0  initial release
// ============================================================================
module sum_fifo #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_push,
    input  logic [DATA_W-1:0] i_push_data,
    output logic              o_head_valid,
    input  logic              i_head_ready,
    output logic [DATA_W-1:0] o_head_data
);

    localparam int c_PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int c_CNT_W = $clog2(DEPTH + 1);
    localparam logic [c_PTR_W-1:0] c_PTR_LAST = c_PTR_W'(DEPTH - 1);

    logic [DATA_W-1:0]  mem_q [DEPTH];
    logic [DATA_W-1:0]  mem_d [DEPTH];
    logic [c_PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [c_PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [c_CNT_W-1:0] count_q, count_d;
    logic               head_valid_q, head_valid_d;
    logic [DATA_W-1:0]  head_data_q, head_data_d;

    logic w_pop;
    logic w_load;
    logic w_bypass;
    logic w_mem_rd;
    logic w_mem_wr;

    always_comb begin
        mem_d        = mem_q;
        rd_ptr_d     = rd_ptr_q;
        wr_ptr_d     = wr_ptr_q;
        count_d      = count_q;
        head_valid_d = head_valid_q;
        head_data_d  = head_data_q;
        w_bypass     = 1'b0;
        w_mem_rd     = 1'b0;
        w_mem_wr     = 1'b0;

        w_pop  = head_valid_q && i_head_ready;
        w_load = !head_valid_q || w_pop;

        // Refill the head: stored entries take priority to keep ordering;
        // an incoming entry bypasses storage only when storage is empty.
        if (w_load) begin
            if (count_q != '0) begin
                head_data_d  = mem_q[rd_ptr_q];
                head_valid_d = 1'b1;
                w_mem_rd     = 1'b1;
                rd_ptr_d     = (rd_ptr_q == c_PTR_LAST) ? '0 : rd_ptr_q + 1'b1;
            end else if (i_push) begin
                head_data_d  = i_push_data;
                head_valid_d = 1'b1;
                w_bypass     = 1'b1;
            end else begin
                head_valid_d = 1'b0;
            end
        end

        if (i_push && !w_bypass) begin
            mem_d[wr_ptr_q] = i_push_data;
            w_mem_wr        = 1'b1;
            wr_ptr_d        = (wr_ptr_q == c_PTR_LAST) ? '0 : wr_ptr_q + 1'b1;
        end

        case ({w_mem_wr, w_mem_rd})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            rd_ptr_q     <= '0;
            wr_ptr_q     <= '0;
            count_q      <= '0;
            head_valid_q <= 1'b0;
            head_data_q  <= '0;
        end else begin
            rd_ptr_q     <= rd_ptr_d;
            wr_ptr_q     <= wr_ptr_d;
            count_q      <= count_d;
            head_valid_q <= head_valid_d;
            head_data_q  <= head_data_d;
        end
    end

    // Storage contents are don't-care after reset; occupancy is tracked by count_q.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign o_head_valid = head_valid_q;
    assign o_head_data  = head_data_q;

endmodule : sum_fifo
`default_nettype wire

// File: rtl/prefix_sum_stage.sv
`default_nettype none
// ============================================================================
//  Module   : prefix_sum_stage
//  Purpose  : Final sum stage of the multiplier's carry-propagate adder.
//             Realigns half-sum bits and carry-in with the prefix tree's
//             group G/P outputs, forms sum / carry-out / all-propagate and
//             buffers them behind a valid/ready output. Input acceptance is
//             credit-based so the unstallable tree never overflows the buffer.
//  Ports    : clk, rst (sync, active-low)
//             in_valid/in_ready, in_h, in_cin       operand side
//             tree_g, tree_p                        prefix tree outputs
//             out_valid/out_ready, out_sum,
//             out_cout, out_allp                    result side
//  Revision : 1.0  initial release
// ============================================================================
module prefix_sum_stage
    import prefix_pkg::*;
#(
    parameter int WIDTH      = c_DEFAULT_WIDTH,
    parameter int TREE_LAT   = tree_latency(c_DEFAULT_WIDTH, KOGGE_STONE, 1'b1),
    parameter int FIFO_DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_h,
    input  logic             in_cin,
    input  logic [WIDTH-1:0] tree_g,
    input  logic [WIDTH-1:0] tree_p,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout,
    output logic             out_allp
);

    localparam int c_USED_W = $clog2(FIFO_DEPTH + 1);
    localparam int c_ENTRY_W = WIDTH + 2;
    localparam logic [c_USED_W-1:0] c_USED_MAX = c_USED_W'(FIFO_DEPTH);

    logic                 w_accept;
    logic                 w_pop;
    logic                 w_tail_valid;
    logic [WIDTH-1:0]     w_tail_h;
    logic                 w_tail_cin;
    logic [WIDTH-1:0]     w_carry;
    logic [WIDTH-1:0]     w_sum;
    logic                 w_cout;
    logic [c_ENTRY_W-1:0] w_entry;
    logic [c_ENTRY_W-1:0] w_head;
    logic [c_USED_W-1:0]  used_q, used_d;

    // in_ready looks only at registered credit so a same-cycle pop does not
    // combinationally reopen the input.
    assign in_ready = rst && (used_q < c_USED_MAX);
    assign w_accept = in_valid && in_ready;
    assign w_pop    = out_valid && out_ready;

    // ------------------------------------------------------------------
    // Delay line: carries {valid, h, cin} alongside the tree so its tail
    // lines up with tree_g/tree_p in the same cycle.
    // ------------------------------------------------------------------
    generate
        if (TREE_LAT > 0) begin : g_delay
            logic [TREE_LAT-1:0] dl_valid_q, dl_valid_d;
            logic [TREE_LAT-1:0] dl_cin_q,   dl_cin_d;
            logic [WIDTH-1:0]    dl_h_q [TREE_LAT];
            logic [WIDTH-1:0]    dl_h_d [TREE_LAT];

            always_comb begin
                dl_valid_d    = dl_valid_q;
                dl_cin_d      = dl_cin_q;
                dl_h_d        = dl_h_q;
                dl_valid_d[0] = w_accept;
                dl_cin_d[0]   = in_cin;
                dl_h_d[0]     = in_h;
                for (int i = 1; i < TREE_LAT; i++) begin
                    dl_valid_d[i] = dl_valid_q[i-1];
                    dl_cin_d[i]   = dl_cin_q[i-1];
                    dl_h_d[i]     = dl_h_q[i-1];
                end
            end

            always_ff @(posedge clk) begin
                if (!rst) begin
                    dl_valid_q <= '0;
                end else begin
                    dl_valid_q <= dl_valid_d;
                end
            end

            // Payload only matters when its valid bit is set.
            always_ff @(posedge clk) begin
                dl_cin_q <= dl_cin_d;
                dl_h_q   <= dl_h_d;
            end

            assign w_tail_valid = dl_valid_q[TREE_LAT-1];
            assign w_tail_cin   = dl_cin_q[TREE_LAT-1];
            assign w_tail_h     = dl_h_q[TREE_LAT-1];
        end else begin : g_no_delay
            assign w_tail_valid = w_accept;
            assign w_tail_cin   = in_cin;
            assign w_tail_h     = in_h;
        end
    endgenerate

    // ------------------------------------------------------------------
    // Carries: c[0] = cin, c[i] = G[i-1:0] | P[i-1:0] & cin.
    // ------------------------------------------------------------------
    assign w_carry = {tree_g[WIDTH-2:0] | (tree_p[WIDTH-2:0] & {(WIDTH-1){w_tail_cin}}),
                      w_tail_cin};
    assign w_sum   = w_tail_h ^ w_carry;
    assign w_cout  = tree_g[WIDTH-1] | (tree_p[WIDTH-1] & w_tail_cin);
    assign w_entry = {w_sum, w_cout, tree_p[WIDTH-1]};

    // ------------------------------------------------------------------
    // Credit counter: counts every accepted operand until its result pops,
    // covering entries still in the delay line as well as buffered ones.
    // ------------------------------------------------------------------
    always_comb begin
        used_d = used_q;
        case ({w_accept, w_pop})
            2'b10:   used_d = used_q + 1'b1;
            2'b01:   used_d = used_q - 1'b1;
            default: used_d = used_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            used_q <= '0;
        end else begin
            used_q <= used_d;
        end
    end

    sum_fifo #(
        .DATA_W (c_ENTRY_W),
        .DEPTH  (FIFO_DEPTH)
    ) u_sum_fifo (
        .clk          (clk),
        .rst          (rst),
        .i_push       (w_tail_valid),
        .i_push_data  (w_entry),
        .o_head_valid (out_valid),
        .i_head_ready (out_ready),
        .o_head_data  (w_head)
    );

    assign out_sum  = w_head[c_ENTRY_W-1:2];
    assign out_cout = w_head[1];
    assign out_allp = w_head[0];

endmodule : prefix_sum_stage
`default_nettype wire

// File: doc/prefix_sum_stage.md
# prefix_sum_stage

Final sum stage of the fast multiplier's carry-propagate adder. It sits directly downstream of the parallel prefix tree and consumes the tree's group generate/propagate outputs. It realigns them with the half-sum bits and carry-in captured when the operands entered the tree. From these it forms the sum and carry-out, and buffers the results behind a valid/ready output so that consumer backpressure never has to stall the unstallable tree.

## Interface
Parameters:
- WIDTH, 64: operand and sum width (≥ 2).
- TREE_LAT, 6: prefix-tree latency in cycles; 0 means a combinational tree. Set from the shared package function.
- FIFO_DEPTH, 8: output buffer entries (≥ 1). Full throughput requires ≥ TREE_LAT + 2.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset; synchronous, active-low.
- in_valid  in  1  upstream holds a new operand pair. Its g/p/a terms drive the prefix tree this cycle.
- in_ready  out  1  this block accepts; the transfer happens on in_valid && in_ready.
- in_h  in  WIDTH  half-sum bits (a XOR b) of the accepted pair.
- in_cin  in  1  carry-in of the accepted pair.
- tree_g  in  WIDTH  prefix tree g_out: bit i = G[i:0].
- tree_p  in  WIDTH  prefix tree p_out: bit i = P[i:0].
- out_valid  out  1  FIFO head is valid.
- out_ready  in  1  consumer accepts the head.
- out_sum  out  WIDTH  sum of the head entry.
- out_cout  out  1  carry-out of the head entry.
- out_allp  out  1  P[WIDTH-1:0] of the head entry, for carry-select/overflow use.

## Operation
- Delay line: TREE_LAT stages hold {valid, h, cin}. On acceptance, stage 0 loads {1, in_h, in_cin}; otherwise it loads valid = 0. All stages shift every cycle unconditionally.
- Alignment: the tail of the delay line is aligned cycle-exactly with tree_g/tree_p. With TREE_LAT = 0, the live inputs are used directly.
- Carry and sum:
  - c[0] = cin.
  - c[i] = G[i-1:0] | (P[i-1:0] & cin) for i ≥ 1.
  - sum[i] = h[i] ^ c[i].
  - cout = G[WIDTH-1:0] | (P[WIDTH-1:0] & cin).
  - allp = P[WIDTH-1:0].
  - All arithmetic is WIDTH bits with no extension.
- FIFO push: when the tail valid is 1, {sum, cout, allp} is written to the FIFO. Tail entries with valid = 0 are discarded, so whatever the tree computes in unaccepted cycles is ignored.
- Credit counter `used` (0..FIFO_DEPTH):
  - +1 on input acceptance, −1 on output pop (out_valid && out_ready).
  - Both in the same cycle: unchanged.
- in_ready = rst && (used < FIFO_DEPTH). This guarantees the FIFO can never overflow, even with every delay-line entry in flight.
- Order is strictly preserved.

## Timing
- Latency from an accepted input to out_valid of that entry is TREE_LAT + 1 cycles when the FIFO is empty and out_ready = 1.
- Throughput is 1 per cycle when FIFO_DEPTH ≥ TREE_LAT + 2.
- Outputs are registered; out_sum/out_cout/out_allp are stable while out_valid && !out_ready.
- Empty FIFO: out_valid = 0, and out_sum/out_cout/out_allp hold their last values.
- Full credit (used = FIFO_DEPTH): in_ready = 0 in that same cycle. A pop in that cycle does not raise in_ready until the next cycle, because in_ready depends only on registered `used`.
- Reset values while rst = 0: all delay-line valids 0, used = 0, FIFO empty, in_ready = 0, out_valid = 0, out_sum = 0, out_cout = 0, out_allp = 0.
- in_ready = 1 in the first cycle after rst rises.
- Reset mid-operation discards all in-flight and buffered entries; nothing from before reset ever appears on the output.
- FIFO pointers wrap modulo FIFO_DEPTH. Push and pop in the same cycle on a non-empty FIFO keeps the count unchanged.

## Structure
- Shared package prefix_pkg holds:
  - the technique enum (KOGGE_STONE = 0, SKLANSKY = 1, BRENT_KUNG = 2);
  - function tree_levels(width, technique), which returns clog2(width) for Kogge-Stone/Sklansky and 2·clog2(width) − 1 for Brent-Kung;
  - function tree_latency(width, technique, pipe), which returns tree_levels or 0.
- Sub-module sum_fifo: a synchronous FIFO parameterised by width and depth, with registered head outputs and the same reset.

## Test plan
Bench settings: WIDTH = 8, TREE_LAT = 3. A reference Kogge-Stone tree model drives tree_g/tree_p.
- Single op: a = 0xFF, b = 0x01, cin = 0, out_ready = 1 → out_valid exactly 4 cycles after acceptance with sum 0x00, cout 1, allp 0.
- Carry-in propagation: a = 0xF0, b = 0x0F, cin = 1 → sum 0x00, cout 1, allp 1.
- Back-to-back stream: 100 random pairs with out_ready = 1 → 100 results in order, one per cycle, all matching a + b + cin.
- Backpressure: hold out_ready = 0 while streaming → in_ready falls after exactly 8 acceptances with no loss. Releasing out_ready drains 8 results in order, and in_ready returns one cycle after the first pop.
- Gaps: in_valid toggling every other cycle with random tree noise on idle cycles → only accepted pairs produce outputs.
- Reset mid-stream: rst = 0 for 1 cycle with 3 in flight and 2 buffered → out_valid 0 and all outputs 0 during reset, no stale results afterwards, in_ready = 1 the next cycle.
